// File: rtl/cntclk_core.sv
// Loadable, auto-reloading down counter used as an event timer and clock divider.
// The count is read back on io_value whenever the bus is not being used to load.
module cntclk_core #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  inout  wire  [WIDTH-1:0] io_value,
  output logic             o_zero,
  output logic             o_clk
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             div_clk_q, div_clk_d;
  logic             count_is_zero;

  assign count_is_zero = (count_q == '0);

  // A load always wins over the terminal-count reload, so a zero coincident
  // with a load does not toggle the divided clock.
  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    div_clk_d = div_clk_q;
    if (i_load) begin
      count_d  = io_value;
      reload_d = io_value;
    end else if (count_is_zero) begin
      count_d   = reload_q;
      div_clk_d = ~div_clk_q;
    end else begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q   <= '0;
      reload_q  <= '0;
      div_clk_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      div_clk_q <= div_clk_d;
    end
  end

  assign o_zero   = count_is_zero;
  assign o_clk    = div_clk_q;
  assign io_value = i_load ? {WIDTH{1'bz}} : count_q;

endmodule

// File: tb/tb_cntclk_core.sv
// Self-checking bench for cntclk_core: directed table, reset/corner sequences
// and randomized loads checked against a period-arithmetic reference model.
module tb_cntclk_core;

  logic       clk;
  logic       rst_n;
  logic       load8, load4;
  logic       en8, en4;
  logic [7:0] drv8;
  logic [3:0] drv4;
  wire  [7:0] bus8;
  wire  [3:0] bus4;
  logic       zero8, zero4, dclk8, dclk4;

  assign bus8 = en8 ? drv8 : 8'bz;
  assign bus4 = en4 ? drv4 : 4'bz;

  cntclk_core #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load8),
    .io_value(bus8), .o_zero(zero8), .o_clk(dclk8)
  );

  cntclk_core #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load4),
    .io_value(bus4), .o_zero(zero4), .o_clk(dclk4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: after loading V, k edges later the count is
  // V - (k mod (V+1)) and the divided clock has toggled floor(k/(V+1)) times.
  int   v8 = 0, k8 = 0;
  logic b8 = 1'b0;
  int   v4 = 0, k4 = 0;
  logic b4 = 1'b0;

  function automatic int m_count(int v, int k);
    return v - (k % (v + 1));
  endfunction

  function automatic logic m_clk(int v, int k, logic b);
    return b ^ logic'((k / (v + 1)) % 2);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    v8 = 0; k8 = 0; b8 = 1'b0;
    v4 = 0; k4 = 0; b4 = 1'b0;
  endtask

  task automatic check_model();
    chk("cnt8",  {24'd0, bus8},  m_count(v8, k8));
    chk("zero8", {31'd0, zero8}, {31'd0, m_count(v8, k8) == 0});
    chk("clk8",  {31'd0, dclk8}, {31'd0, m_clk(v8, k8, b8)});
    chk("cnt4",  {28'd0, bus4},  m_count(v4, k4));
    chk("zero4", {31'd0, zero4}, {31'd0, m_count(v4, k4) == 0});
    chk("clk4",  {31'd0, dclk4}, {31'd0, m_clk(v4, k4, b4)});
  endtask

  // Called just after a rising edge; drives one cycle of inputs, advances the
  // model over the next edge and checks both instances afterwards.
  task automatic step(logic l8, logic [7:0] val8, logic l4, logic [3:0] val4);
    load8 = l8; en8 = l8; drv8 = val8;
    load4 = l4; en4 = l4; drv4 = val4;
    @(posedge clk);
    if (l8) begin b8 = m_clk(v8, k8, b8); v8 = int'(val8); k8 = 0; end
    else k8++;
    if (l4) begin b4 = m_clk(v4, k4, b4); v4 = int'(val4); k4 = 0; end
    else k4++;
    #1;
    load8 = 1'b0; en8 = 1'b0; drv8 = '0;
    load4 = 1'b0; en4 = 1'b0; drv4 = '0;
    #1;
    check_model();
  endtask

  typedef struct {
    bit       ld;
    bit [7:0] val;
    int       cnt;
    bit       zero;
    bit       dclk;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(bit ld, bit [7:0] val, int cnt, bit zero, bit dclk);
    vec_t v;
    v.ld = ld; v.val = val; v.cnt = cnt; v.zero = zero; v.dclk = dclk;
    tbl.push_back(v);
  endtask

  initial begin
    int zero_pulses;
    rst_n = 1'b0;
    load8 = 1'b0; en8 = 1'b0; drv8 = '0;
    load4 = 1'b0; en4 = 1'b0; drv4 = '0;
    model_reset();
    #2;
    chk("rst_cnt",  {24'd0, bus8},  32'd0);
    chk("rst_zero", {31'd0, zero8}, 32'd1);
    chk("rst_clk",  {31'd0, dclk8}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Load 2 and free-run, FSM-style reload of 8 after a zero, load at zero,
    // load of 0, then load of 3.
    addv(1, 2, 2, 0, 0); addv(0, 0, 1, 0, 0); addv(0, 0, 0, 1, 0);
    addv(0, 0, 2, 0, 1); addv(0, 0, 1, 0, 1); addv(0, 0, 0, 1, 1);
    addv(0, 0, 2, 0, 0);
    addv(1, 8, 8, 0, 0);
    for (int i = 7; i >= 1; i--) addv(0, 0, i, 0, 0);
    addv(0, 0, 0, 1, 0);
    addv(1, 5, 5, 0, 0);
    for (int i = 4; i >= 1; i--) addv(0, 0, i, 0, 0);
    addv(0, 0, 0, 1, 0);
    addv(1, 0, 0, 1, 0); addv(0, 0, 0, 1, 1); addv(0, 0, 0, 1, 0);
    addv(1, 3, 3, 0, 0); addv(0, 0, 2, 0, 0); addv(0, 0, 1, 0, 0);
    addv(0, 0, 0, 1, 0); addv(0, 0, 3, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ld, tbl[i].val, 1'b0, 4'd0);
      chk("tbl_cnt",  {24'd0, bus8},  tbl[i].cnt);
      chk("tbl_zero", {31'd0, zero8}, {31'd0, tbl[i].zero});
      chk("tbl_clk",  {31'd0, dclk8}, {31'd0, tbl[i].dclk});
    end

    // WIDTH=4 at full scale: 16-cycle zero period with no overflow.
    step(1'b0, 8'd0, 1'b1, 4'd15);
    zero_pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 8'd0, 1'b0, 4'd0);
      if (zero4) zero_pulses++;
    end
    chk("w4_pulses", zero_pulses, 32'd2);

    // Asynchronous reset mid-count, no clock edge in between.
    step(1'b1, 8'd40, 1'b1, 4'd9);
    for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("amid_cnt",  {24'd0, bus8},  32'd0);
    chk("amid_zero", {31'd0, zero8}, 32'd1);
    chk("amid_clk",  {31'd0, dclk8}, 32'd0);
    chk("amid_cnt4", {28'd0, bus4},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_model();

    // Randomized loads against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
